rca_burst_accumulator: RTL

- Upstream sequencer and accumulator for the existing 5-bit/4-bit ripple_carry_adder.
- Accepts a stream of 4-bit operands over a valid/ready handshake.
- Feeds the running total as A and each operand as B into the adder, then registers SUM back as the new total.
- After BURST_LEN operands, presents the 5-bit total and a sticky overflow flag downstream over a second valid/ready handshake.

---
 rtl/rca_pkg.sv | 6 +
 rtl/ripple_carry_adder.sv | 16 +
 rtl/rca_burst_accumulator.sv | 66 ++++++
 3 files changed

// File: rtl/rca_pkg.sv
// rca_pkg: shared adder widths and sequencer state encoding for the burst accumulator.
package rca_pkg;
  localparam int A_W = 5;
  localparam int B_W = 4;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: 5-bit + zero-extended 4-bit ripple adder; no carry-out, result wraps modulo 32.
module ripple_carry_adder import rca_pkg::*; (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [A_W-1:0] sum
);
  logic [A_W-1:0] bx, c;
  assign bx = {{(A_W-B_W){1'b0}}, b};
  assign c[0] = 1'b0;
  for (genvar i = 0; i < A_W; i++) begin : g_bit
    assign sum[i] = a[i] ^ bx[i] ^ c[i];
    if (i < A_W - 1) begin : g_carry
      assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end
endmodule

// File: rtl/rca_burst_accumulator.sv
// rca_burst_accumulator: accumulates BURST_LEN operands through ripple_carry_adder and hands the total downstream.
// Define RCA_ACC_SATURATE_EN to clamp the total at 31 on overflow instead of wrapping.
module rca_burst_accumulator import rca_pkg::*; #(
  parameter int BURST_LEN = 4,
  localparam int CNT_W = $clog2(BURST_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [B_W-1:0]   in_data,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [A_W-1:0]   out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);
  state_t state, state_n;
  logic [A_W-1:0] total, total_n, sum, acc_sum;
  logic [CNT_W-1:0] count_n;
  logic ovf_n, wrap, accept, done;
  ripple_carry_adder u_add (.a(total), .b(in_data), .sum(sum));
  // the adder drops its carry, so a wrap shows up as the sum falling below the old total
  assign wrap = sum < total;
`ifdef RCA_ACC_SATURATE_EN
  assign acc_sum = wrap ? '1 : sum;
`else
  assign acc_sum = sum;
`endif
  assign in_ready = state != HOLD && !clear;
  assign accept = in_valid && in_ready;
  assign done = state == HOLD && out_ready;
  assign out_valid = state == HOLD;
  assign out_sum = total;
  always_comb begin
    state_n = state;
    total_n = total;
    ovf_n = out_ovf;
    count_n = out_count;
    if (clear || done) begin
      state_n = IDLE;
      total_n = '0;
      ovf_n = 1'b0;
      count_n = '0;
    end else if (accept) begin
      total_n = acc_sum;
      ovf_n = out_ovf | wrap;
      count_n = out_count + 1'b1;
      state_n = count_n == CNT_W'(BURST_LEN) ? HOLD : ACCUM;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      total <= '0;
      out_ovf <= 1'b0;
      out_count <= '0;
    end else begin
      state <= state_n;
      total <= total_n;
      out_ovf <= ovf_n;
      out_count <= count_n;
    end
  end
endmodule
